// File: rtl/f2h_sdram_arbiter.sv
// Two-master round-robin arbiter in front of the HPS FPGA-to-SDRAM Avalon-MM
// port. Single-beat reads/writes, grant held across slave stalls, and a 1-bit
// ID FIFO that steers in-order read returns back to the issuing master.
module f2h_sdram_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 27,
  parameter int MAX_PEND = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,

  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,

  output logic [ADDR_W-1:0]     s_address,
  output logic                  s_read,
  output logic                  s_write,
  output logic [DATA_W-1:0]     s_writedata,
  output logic [DATA_W/8-1:0]   s_byteenable,
  input  logic                  s_waitrequest,
  input  logic [DATA_W-1:0]     s_readdata,
  input  logic                  s_readdatavalid,

  output logic                  err
);

  localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_PEND);

  typedef enum logic [1:0] {
    ARB_OPEN    = 2'd0,
    ARB_HOLD_M0 = 2'd1,
    ARB_HOLD_M1 = 2'd2
  } arb_state_t;

  arb_state_t state_q, state_d;

  logic [1:0]       rst_pipe;
  logic             rst_sync_n;

  logic             last_q;
  logic             lock;
  logic             lock_id;

  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             fifo_mem [MAX_PEND];
  logic             fifo_full;
  logic             fifo_empty;
  logic             head_id;

  logic             elig0;
  logic             elig1;
  logic             sel;
  logic             sel_valid;
  logic             cmd_read;
  logic             cmd_write;
  logic             issue;
  logic             accept;
  logic             push;
  logic             pop;

  // Reset synchronizer: asserts immediately, releases two clocks after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_pipe <= '0;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_sync_n = rst_pipe[1];

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign head_id    = fifo_mem[rd_ptr_q];

  assign lock    = (state_q != ARB_OPEN);
  assign lock_id = (state_q == ARB_HOLD_M1);

  // Eligibility, round-robin selection and the combinational command path.
  // Everything is gated by the synchronized reset so the slave sees no command
  // and both masters see waitrequest while the block is held in reset.
  always_comb begin
    elig0          = rst_sync_n & (m0_write | (m0_read & ~fifo_full));
    elig1          = rst_sync_n & (m1_write | (m1_read & ~fifo_full));
    sel            = 1'b0;
    sel_valid      = 1'b0;
    cmd_read       = 1'b0;
    cmd_write      = 1'b0;
    issue          = 1'b0;
    accept         = 1'b0;
    s_address      = m0_address;
    s_writedata    = m0_writedata;
    s_byteenable   = m0_byteenable;
    s_read         = 1'b0;
    s_write        = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;

    if (lock) begin
      sel       = lock_id;
      sel_valid = rst_sync_n;
    end else if (elig0 && elig1) begin
      sel       = ~last_q;
      sel_valid = 1'b1;
    end else if (elig0) begin
      sel       = 1'b0;
      sel_valid = 1'b1;
    end else if (elig1) begin
      sel       = 1'b1;
      sel_valid = 1'b1;
    end

    if (sel) begin
      s_address    = m1_address;
      s_writedata  = m1_writedata;
      s_byteenable = m1_byteenable;
      cmd_read     = sel_valid & m1_read & ~fifo_full;
      cmd_write    = sel_valid & m1_write;
    end else begin
      cmd_read     = sel_valid & m0_read & ~fifo_full;
      cmd_write    = sel_valid & m0_write;
    end

    s_read         = cmd_read;
    s_write        = cmd_write;
    issue          = cmd_read | cmd_write;
    accept         = issue & ~s_waitrequest;
    m0_waitrequest = ~(accept & ~sel);
    m1_waitrequest = ~(accept & sel);
  end

  // Grant lock next state: hold the stalled master until its command is taken.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = ARB_OPEN;
    end else if (issue) begin
      state_d = sel ? ARB_HOLD_M1 : ARB_HOLD_M0;
    end
  end

  // Lock state and round-robin history registers.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q <= ARB_OPEN;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q <= sel;
      end
    end
  end

  assign push = accept & cmd_read;
  assign pop  = s_readdatavalid & ~fifo_empty;

  // ID FIFO storage: records which master issued each outstanding read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= sel;
    end
  end

  // ID FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Read return routing to the FIFO head master, plus sticky orphan-return error.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      m0_readdata      <= '0;
      m1_readdata      <= '0;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
      err              <= 1'b0;
    end else begin
      m0_readdatavalid <= pop & ~head_id;
      m1_readdatavalid <= pop & head_id;
      if (pop) begin
        m0_readdata <= s_readdata;
        m1_readdata <= s_readdata;
      end
      if (s_readdatavalid && fifo_empty) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_f2h_sdram_arbiter.sv
// Directed bench for f2h_sdram_arbiter: a queue-based reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_f2h_sdram_arbiter;

  localparam int DW = 64;
  localparam int AW = 27;
  localparam int MP = 8;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;

  logic [AW-1:0] m0_address, m1_address, s_address;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [BW-1:0] m0_byteenable, m1_byteenable, s_byteenable;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic          s_read, s_write, s_waitrequest, s_readdatavalid;
  logic [DW-1:0] s_readdata;
  logic          err;

  int n_vec  = 0;
  int n_fail = 0;

  f2h_sdram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_PEND(MP)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_byteenable    (m0_byteenable),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_byteenable    (m1_byteenable),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .s_address        (s_address),
    .s_read           (s_read),
    .s_write          (s_write),
    .s_writedata      (s_writedata),
    .s_byteenable     (s_byteenable),
    .s_waitrequest    (s_waitrequest),
    .s_readdata       (s_readdata),
    .s_readdatavalid  (s_readdatavalid),
    .err              (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (state after the next clock edge) -------
  bit            md_last;
  bit            md_lock;
  bit            md_lock_id;
  bit            md_err;
  bit            md_rdv0;
  bit            md_rdv1;
  logic [DW-1:0] md_rdata;
  bit            md_q[$];

  always @(negedge clk) begin
    bit full, e0, e1, g, gv, cr, cw, acc, rd_g, wr_g;
    logic [AW-1:0] a_g;
    logic [DW-1:0] d_g;
    logic [BW-1:0] b_g;
    if (!reset_n) begin
      chk("rst_m0_wait", m0_waitrequest, 1);
      chk("rst_m1_wait", m1_waitrequest, 1);
      chk("rst_s_cmd", {s_read, s_write}, 0);
      chk("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
      chk("rst_rdata0", m0_readdata, 0);
      chk("rst_rdata1", m1_readdata, 0);
      chk("rst_err", err, 0);
      md_last = 1; md_lock = 0; md_lock_id = 0; md_err = 0;
      md_rdv0 = 0; md_rdv1 = 0; md_rdata = '0;
      md_q.delete();
    end else begin
      full = (md_q.size() >= MP);
      e0 = m0_write || (m0_read && !full);
      e1 = m1_write || (m1_read && !full);
      gv = 1; g = 0;
      if (md_lock) g = md_lock_id;
      else if (e0 && e1) g = !md_last;
      else if (e0) g = 0;
      else if (e1) g = 1;
      else gv = 0;
      rd_g = g ? m1_read : m0_read;
      wr_g = g ? m1_write : m0_write;
      a_g  = g ? m1_address : m0_address;
      d_g  = g ? m1_writedata : m0_writedata;
      b_g  = g ? m1_byteenable : m0_byteenable;
      cr = gv && rd_g && !full;
      cw = gv && wr_g;
      acc = (cr || cw) && !s_waitrequest;

      chk("s_read", s_read, cr);
      chk("s_write", s_write, cw);
      if (cr || cw) chk("s_address", s_address, a_g);
      if (cw) begin
        chk("s_writedata", s_writedata, d_g);
        chk("s_byteenable", s_byteenable, b_g);
      end
      chk("m0_wait", m0_waitrequest, !(acc && g == 0));
      chk("m1_wait", m1_waitrequest, !(acc && g == 1));
      chk("m0_rdv", m0_readdatavalid, md_rdv0);
      chk("m1_rdv", m1_readdatavalid, md_rdv1);
      chk("m0_rdata", m0_readdata, md_rdata);
      chk("m1_rdata", m1_readdata, md_rdata);
      chk("err", err, md_err);

      if (acc) begin
        md_last = g;
        md_lock = 0;
      end else if (cr || cw) begin
        md_lock = 1;
        md_lock_id = g;
      end
      md_rdv0 = 0; md_rdv1 = 0;
      if (s_readdatavalid) begin
        if (md_q.size() == 0) md_err = 1;
        else begin
          if (md_q.pop_front()) md_rdv1 = 1; else md_rdv0 = 1;
          md_rdata = s_readdata;
        end
      end
      if (acc && cr) md_q.push_back(g);
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic drv(input bit r0, input bit w0, input logic [AW-1:0] a0,
                     input bit r1, input bit w1, input logic [AW-1:0] a1,
                     input bit sw, input bit rdv, input logic [DW-1:0] rd);
    m0_read = r0; m0_write = w0; m0_address = a0;
    m0_writedata = {32'hD0D0_0000, 5'd0, a0}; m0_byteenable = 8'h0F;
    m1_read = r1; m1_write = w1; m1_address = a1;
    m1_writedata = {32'hD1D1_0000, 5'd0, a1}; m1_byteenable = 8'hF0;
    s_waitrequest = sw; s_readdatavalid = rdv; s_readdata = rd;
  endtask

  task automatic idle();
    drv(0, 0, '0, 0, 0, '0, 0, 0, '0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    repeat (3) next();
    reset_n = 1'b1;
    repeat (4) next();

    // Both masters stream writes: m0 first, then strict alternation.
    for (int k = 0; k < 6; k++) begin
      drv(0, 1, 'h100, 0, 1, 'h200, 0, 0, '0);
      #3;
      chk("t1_addr", s_address, (k % 2 == 0) ? 'h100 : 'h200);
      chk("t1_m0_wait", m0_waitrequest, k % 2);
      chk("t1_m1_wait", m1_waitrequest, (k + 1) % 2);
      next();
    end
    idle(); next();

    // Lone m0 write so m1 wins the next contention.
    drv(0, 1, 'h111, 0, 0, '0, 0, 0, '0); next();

    // m1 read stalled three cycles; grant must not move to m0.
    for (int k = 0; k < 4; k++) begin
      drv(0, 1, 'h120, 1, 0, 'h2A, k < 3, 0, '0);
      #3;
      chk("t2_addr", s_address, 'h2A);
      chk("t2_s_read", s_read, 1);
      chk("t2_m1_wait", m1_waitrequest, k < 3);
      chk("t2_m0_wait", m0_waitrequest, 1);
      next();
    end
    drv(0, 1, 'h120, 0, 0, '0, 0, 0, '0);
    #3;
    chk("t2_m0_grant", m0_waitrequest, 0);
    chk("t2_m0_addr", s_address, 'h120);
    next();
    drv(0, 0, '0, 0, 0, '0, 0, 1, 'hAA); next();
    idle();
    #3;
    chk("t2_ret_m1_rdv", m1_readdatavalid, 1);
    chk("t2_ret_m1_data", m1_readdata, 'hAA);
    chk("t2_ret_m0_rdv", m0_readdatavalid, 0);
    next();

    // m0 A, m1 B, m0 C; returns routed in issue order.
    drv(1, 0, 'h10, 0, 0, '0, 0, 0, '0); next();
    drv(0, 0, '0, 1, 0, 'h20, 0, 0, '0); next();
    drv(1, 0, 'h30, 0, 0, '0, 0, 0, '0); next();
    drv(0, 0, '0, 0, 0, '0, 0, 1, 'h11); next();
    drv(0, 0, '0, 0, 0, '0, 0, 1, 'h22);
    #3;
    chk("t3_m0_rdv_a", m0_readdatavalid, 1);
    chk("t3_m0_data_a", m0_readdata, 'h11);
    next();
    drv(0, 0, '0, 0, 0, '0, 0, 1, 'h33);
    #3;
    chk("t3_m1_rdv_b", m1_readdatavalid, 1);
    chk("t3_m1_data_b", m1_readdata, 'h22);
    chk("t3_m0_rdv_b", m0_readdatavalid, 0);
    next();
    idle();
    #3;
    chk("t3_m0_rdv_c", m0_readdatavalid, 1);
    chk("t3_m0_data_c", m0_readdata, 'h33);
    next();

    // Fill the ID FIFO from m0, then probe full behaviour.
    for (int i = 0; i < MP; i++) begin
      drv(1, 0, AW'('h300 + i), 0, 0, '0, 0, 0, '0);
      #3;
      chk("t4_fill_m0_wait", m0_waitrequest, 0);
      next();
    end
    drv(1, 0, 'h308, 0, 1, 'h208, 0, 0, '0);
    #3;
    chk("t4_full_m0_wait", m0_waitrequest, 1);
    chk("t4_full_m1_wait", m1_waitrequest, 0);
    chk("t4_full_s_write", s_write, 1);
    chk("t4_full_s_addr", s_address, 'h208);
    next();
    drv(1, 0, 'h308, 0, 0, '0, 0, 1, 'h1000);
    #3;
    chk("t4_pop_m0_wait", m0_waitrequest, 1);
    chk("t4_pop_s_read", s_read, 0);
    next();
    drv(1, 0, 'h308, 0, 0, '0, 0, 0, '0);
    #3;
    chk("t4_freed_m0_wait", m0_waitrequest, 0);
    chk("t4_freed_addr", s_address, 'h308);
    chk("t4_freed_rdv", m0_readdatavalid, 1);
    chk("t4_freed_data", m0_readdata, 'h1000);
    next();
    for (int i = 0; i < MP; i++) begin
      drv(0, 0, '0, 0, 0, '0, 0, 1, DW'('h1001 + i));
      next();
    end
    idle(); next(); next();

    // Orphan return sets a sticky error.
    drv(0, 0, '0, 0, 0, '0, 0, 1, 'hDEAD); next();
    idle();
    #3;
    chk("t5_err_set", err, 1);
    chk("t5_no_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
    next(); next();
    #3;
    chk("t5_err_held", err, 1);

    // Reset with reads outstanding discards them.
    drv(0, 0, '0, 1, 0, 'h40, 0, 0, '0); next();
    drv(0, 0, '0, 1, 0, 'h41, 0, 0, '0); next();
    drv(0, 1, 'h50, 0, 0, '0, 0, 0, '0);
    reset_n = 1'b0;
    #3;
    chk("t5_rst_m0_wait", m0_waitrequest, 1);
    chk("t5_rst_s_write", s_write, 0);
    chk("t5_rst_err", err, 0);
    next(); next();
    idle(); next();
    reset_n = 1'b1;
    repeat (4) next();
    drv(0, 0, '0, 0, 0, '0, 0, 1, 'hBEEF); next();
    idle();
    #3;
    chk("t5_post_rst_err", err, 1);
    chk("t5_post_rst_rdv", m1_readdatavalid, 0);
    next(); next();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/f2h_sdram_arbiter.md
# f2h_sdram_arbiter

Two-master arbiter in the FPGA fabric sharing the HPS FPGA-to-SDRAM Avalon-MM slave port between two fabric requesters (m0, m1). Grants single-beat reads and writes round-robin, keeps the grant stable across slave stalls, and tracks outstanding pipelined reads in an ID FIFO so returning data reaches the master that issued the read. Sits between the fabric masters and the `system` instance's f2h_sdram port in the top level.

## Interface
- DATA_W, 64, data width of all read/write data buses; byteenable is DATA_W/8
- ADDR_W, 27, word address width
- MAX_PEND, 8, outstanding-read capacity; power of 2, 2..32
- clk  in  1  single clock for all logic
- reset_n  in  1  reset, asynchronous and active-low
- mN_address  in  ADDR_W  master N word address (N = 0, 1)
- mN_read / mN_write  in  1  master N command strobes; never both high
- mN_writedata  in  DATA_W  master N write data
- mN_byteenable  in  DATA_W/8  master N byte enables
- mN_waitrequest  out  1  stall to master N
- mN_readdata  out  DATA_W  read data to master N
- mN_readdatavalid  out  1  read data valid to master N
- s_address, s_read, s_write, s_writedata, s_byteenable  out  as mN_*  command to SDRAM port
- s_waitrequest  in  1  SDRAM port stall
- s_readdata  in  DATA_W  SDRAM read data
- s_readdatavalid  in  1  SDRAM read data valid, in issue order
- err  out  1  sticky: readdatavalid received with no read outstanding

## Operation
- Eligibility: mN eligible when mN_write, or mN_read and ID FIFO not full (count < MAX_PEND, evaluated on registered count, no same-cycle pop bypass).
- Selection (combinational): if lock set, sel = lock_id; else if both eligible, sel = !last; else the single eligible master; else none.
- s_* = selected master's command fields; s_read/s_write = 0 when none selected; address/data/byteenable don't-care then.
- Acceptance: command accepted when selected and s_waitrequest = 0. mN_waitrequest = 0 only for the selected master on acceptance; 1 otherwise (including ineligible read when FIFO full).
- lock: set with lock_id = sel when a command is issued and s_waitrequest = 1; cleared on acceptance. No switching while locked, even if other master requests.
- last: updated to sel on every acceptance; reset value 1 (m0 wins first contention).
- ID FIFO: depth MAX_PEND, 1-bit entries. Push sel on accepted read; pop on s_readdatavalid. Push and pop same cycle: count unchanged.
- Return routing: on s_readdatavalid with FIFO non-empty, register s_readdata to both mN_readdata and pulse mN_readdatavalid for N = FIFO head.
- Empty FIFO with s_readdatavalid: data dropped, no readdatavalid, err set until reset.
- Writes produce no response and never touch the FIFO.

## Timing
- Command path m->s and s_waitrequest->mN_waitrequest: combinational, zero latency.
- Read return: mN_readdatavalid exactly 1 cycle after s_readdatavalid; back-to-back returns sustained at 1 per cycle.
- Throughput: 1 accepted command per cycle when s_waitrequest = 0; alternating when both request continuously.
- Reset (async assert, sync deassert internally): FIFO empty, count 0, lock 0, last 1, err 0, mN_readdatavalid 0, mN_readdata 0, s_read/s_write 0, mN_waitrequest 1 while reset_n = 0.
- Reset mid-operation discards outstanding reads; returns arriving afterwards with empty FIFO set err.

## Test plan
- Both masters issue continuous writes, s_waitrequest = 0 -> s_* alternates m0, m1, m0, ...; first grant m0; each master accepts every second cycle.
- m1 read stalled by s_waitrequest = 1 for 3 cycles while m0 requests -> s_address stays m1's for 4 cycles, m1 accepted cycle 4, m0 granted cycle 5.
- m0 reads A, m1 reads B, m0 reads C; slave returns 0x11, 0x22, 0x33 -> m0 gets 0x11 then 0x33, m1 gets 0x22, each 1 cycle after s_readdatavalid.
- MAX_PEND = 8 reads outstanding from m0 -> m0 read held with waitrequest = 1, m1 write still accepted; one return frees slot, read accepted the following cycle.
- Full FIFO with simultaneous pop and new read request -> read not accepted that cycle, accepted next cycle; count stays ≤ 8.
- s_readdatavalid with no reads outstanding -> no mN_readdatavalid, err = 1 and held; reset_n low clears err and forces mN_waitrequest = 1.
